// File: rtl/ae_gain_ctrl.sv
// Auto-exposure gain controller: per-frame window compare, fixed or proportional step, clamped gain.
// Optional IIR luma smoothing when AE_IIR_SMOOTH_EN is defined (adds one evaluation cycle).
//
//   state  | meaning
//   IDLE   | wait for frame_done & enable, capture luma and configuration
//   FILT   | IIR smoothing of captured luma (AE_IIR_SMOOTH_EN builds only)
//   EVAL   | compute window compare and step size
//   APPLY  | update gain and settle counter unless frozen
module ae_gain_ctrl #(
  parameter int LUMA_W        = 8,
  parameter int GAIN_W        = 16,
  parameter int FRAC_W        = 8,
  parameter int INIT_GAIN     = 256,
  parameter int MIN_GAIN      = 128,
  parameter int MAX_GAIN      = 1024,
  parameter int STEP_SHIFT    = 2,
  parameter int MIN_STEP      = 1,
  parameter int MAX_STEP      = 32,
  parameter int SETTLE_FRAMES = 4,
  parameter int IIR_SHIFT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              freeze,
  input  logic              frame_done,
  input  logic [LUMA_W-1:0] avg_brightness,
  input  logic [LUMA_W-1:0] cfg_target,
  input  logic [LUMA_W-1:0] cfg_hyst,
  input  logic              cfg_mode,
  input  logic [GAIN_W-1:0] cfg_fixed_step,
  output logic [GAIN_W-1:0] gain_out,
  output logic              gain_valid,
  output logic              converged,
  output logic              at_max,
  output logic              at_min
);

  localparam int CNT_W = $clog2(SETTLE_FRAMES + 1);
  localparam logic [GAIN_W-1:0] INIT_G     = GAIN_W'(INIT_GAIN);
  localparam logic [GAIN_W-1:0] MIN_G      = GAIN_W'(MIN_GAIN);
  localparam logic [GAIN_W-1:0] MAX_G      = GAIN_W'(MAX_GAIN);
  localparam logic [GAIN_W-1:0] MIN_STEP_G = GAIN_W'(MIN_STEP);
  localparam logic [GAIN_W-1:0] MAX_STEP_G = GAIN_W'(MAX_STEP);
  localparam logic [CNT_W-1:0]  SETTLE_C   = CNT_W'(SETTLE_FRAMES);
  localparam logic [LUMA_W:0]   LUMA_MAX   = {1'b0, {LUMA_W{1'b1}}};
  // FRAC_W only documents the gain format; the datapath is format-agnostic.
  localparam int UNUSED_FRAC = FRAC_W;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_APPLY, S_FILT} state_t;

  state_t            state_q, state_d;
  logic [LUMA_W-1:0] luma_q, luma_d;
  logic [LUMA_W-1:0] target_q, target_d;
  logic [LUMA_W-1:0] hyst_q, hyst_d;
  logic              mode_q, mode_d;
  logic [GAIN_W-1:0] fstep_q, fstep_d;
  logic              above_q, above_d;
  logic              below_q, below_d;
  logic [GAIN_W-1:0] step_q, step_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              apply_q, apply_d;
  logic [GAIN_W-1:0] gain_out_q, gain_out_d;
  logic              valid_q, valid_d;
  logic              conv_q, conv_d;
  logic              at_max_q, at_max_d;
  logic              at_min_q, at_min_d;

  logic [LUMA_W-1:0] eval_luma;

`ifdef AE_IIR_SMOOTH_EN
  logic signed [LUMA_W:0] y_q, y_d;
  logic                   first_q, first_d;
  logic signed [LUMA_W:0] iir_diff;

  assign eval_luma = y_q[LUMA_W-1:0];
  assign iir_diff  = $signed({1'b0, luma_q}) - y_q;
`else
  localparam int UNUSED_IIR = IIR_SHIFT;
  assign eval_luma = luma_q;
`endif

  logic [LUMA_W:0]        t_ext, h_ext, l_ext;
  logic [LUMA_W:0]        lo_raw, hi_raw, lo, hi;
  logic signed [LUMA_W:0] err;
  logic [LUMA_W:0]        abs_err;
  logic [GAIN_W-1:0]      raw_step, prop_step;
  logic [GAIN_W:0]        sum, diff;
  logic [GAIN_W-1:0]      inc_gain, dec_gain;

  always_comb begin
    t_ext    = {1'b0, target_q};
    h_ext    = {1'b0, hyst_q};
    l_ext    = {1'b0, eval_luma};
    lo_raw   = t_ext - h_ext;
    hi_raw   = t_ext + h_ext;
    lo       = lo_raw[LUMA_W] ? '0 : lo_raw;
    hi       = (hi_raw > LUMA_MAX) ? LUMA_MAX : hi_raw;
    err      = $signed(l_ext - t_ext);
    abs_err  = err[LUMA_W] ? (~err + 1'b1) : err;
    raw_step = GAIN_W'(abs_err >> STEP_SHIFT);
    if (raw_step < MIN_STEP_G)      prop_step = MIN_STEP_G;
    else if (raw_step > MAX_STEP_G) prop_step = MAX_STEP_G;
    else                            prop_step = raw_step;
    // Extra top bit catches carry/borrow before the clamp compare.
    sum      = {1'b0, gain_q} + {1'b0, step_q};
    diff     = {1'b0, gain_q} - {1'b0, step_q};
    inc_gain = (sum[GAIN_W] || (sum[GAIN_W-1:0] > MAX_G)) ? MAX_G : sum[GAIN_W-1:0];
    dec_gain = (diff[GAIN_W] || (diff[GAIN_W-1:0] < MIN_G)) ? MIN_G : diff[GAIN_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    luma_d     = luma_q;
    target_d   = target_q;
    hyst_d     = hyst_q;
    mode_d     = mode_q;
    fstep_d    = fstep_q;
    above_d    = above_q;
    below_d    = below_q;
    step_d     = step_q;
    gain_d     = gain_q;
    cnt_d      = cnt_q;
    apply_d    = 1'b0;
    gain_out_d = gain_q;
    valid_d    = apply_q;
    conv_d     = (cnt_q == SETTLE_C);
    at_max_d   = (gain_q == MAX_G);
    at_min_d   = (gain_q == MIN_G);
`ifdef AE_IIR_SMOOTH_EN
    y_d        = y_q;
    first_d    = first_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          luma_d   = avg_brightness;
          target_d = cfg_target;
          hyst_d   = cfg_hyst;
          mode_d   = cfg_mode;
          fstep_d  = cfg_fixed_step;
`ifdef AE_IIR_SMOOTH_EN
          state_d  = S_FILT;
`else
          state_d  = S_EVAL;
`endif
        end
      end
`ifdef AE_IIR_SMOOTH_EN
      S_FILT: begin
        y_d     = first_q ? $signed({1'b0, luma_q}) : (y_q + (iir_diff >>> IIR_SHIFT));
        first_d = 1'b0;
        state_d = S_EVAL;
      end
`endif
      S_EVAL: begin
        above_d = (l_ext > hi);
        below_d = (l_ext < lo);
        step_d  = mode_q ? prop_step : fstep_q;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        state_d = S_IDLE;
        if (!freeze) begin
          apply_d = 1'b1;
          if (above_q)      gain_d = dec_gain;
          else if (below_q) gain_d = inc_gain;
          if (above_q || below_q) cnt_d = '0;
          else if (cnt_q != SETTLE_C) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable reloads everything on the next edge, including a pending frame_done.
    if (!enable) begin
      state_d    = S_IDLE;
      gain_d     = INIT_G;
      cnt_d      = '0;
      apply_d    = 1'b0;
      gain_out_d = INIT_G;
      valid_d    = 1'b0;
      conv_d     = 1'b0;
      at_max_d   = (INIT_G == MAX_G);
      at_min_d   = (INIT_G == MIN_G);
`ifdef AE_IIR_SMOOTH_EN
      first_d    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      luma_q     <= '0;
      target_q   <= '0;
      hyst_q     <= '0;
      mode_q     <= 1'b0;
      fstep_q    <= '0;
      above_q    <= 1'b0;
      below_q    <= 1'b0;
      step_q     <= '0;
      gain_q     <= INIT_G;
      cnt_q      <= '0;
      apply_q    <= 1'b0;
      gain_out_q <= INIT_G;
      valid_q    <= 1'b0;
      conv_q     <= 1'b0;
      at_max_q   <= 1'b0;
      at_min_q   <= 1'b0;
`ifdef AE_IIR_SMOOTH_EN
      y_q        <= '0;
      first_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      luma_q     <= luma_d;
      target_q   <= target_d;
      hyst_q     <= hyst_d;
      mode_q     <= mode_d;
      fstep_q    <= fstep_d;
      above_q    <= above_d;
      below_q    <= below_d;
      step_q     <= step_d;
      gain_q     <= gain_d;
      cnt_q      <= cnt_d;
      apply_q    <= apply_d;
      gain_out_q <= gain_out_d;
      valid_q    <= valid_d;
      conv_q     <= conv_d;
      at_max_q   <= at_max_d;
      at_min_q   <= at_min_d;
`ifdef AE_IIR_SMOOTH_EN
      y_q        <= y_d;
      first_q    <= first_d;
`endif
    end
  end

  assign gain_out   = gain_out_q;
  assign gain_valid = valid_q;
  assign converged  = conv_q;
  assign at_max     = at_max_q;
  assign at_min     = at_min_q;

endmodule

// File: tb/tb_ae_gain_ctrl.sv
// Directed bench for ae_gain_ctrl (default build): hand-computed gains, flags and latency.
module tb_ae_gain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        freeze;
  logic        frame_done;
  logic [7:0]  avg_brightness;
  logic [7:0]  cfg_target;
  logic [7:0]  cfg_hyst;
  logic        cfg_mode;
  logic [15:0] cfg_fixed_step;
  logic [15:0] gain_out;
  logic        gain_valid;
  logic        converged;
  logic        at_max;
  logic        at_min;

  int vectors = 0;
  int miscompares = 0;

  ae_gain_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .freeze         (freeze),
    .frame_done     (frame_done),
    .avg_brightness (avg_brightness),
    .cfg_target     (cfg_target),
    .cfg_hyst       (cfg_hyst),
    .cfg_mode       (cfg_mode),
    .cfg_fixed_step (cfg_fixed_step),
    .gain_out       (gain_out),
    .gain_valid     (gain_valid),
    .converged      (converged),
    .at_max         (at_max),
    .at_min         (at_min)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge with the FSM idle; checks latency, value and pulse width.
  task automatic do_frame(input string tag, input logic [7:0] luma, input logic [15:0] exp_gain,
                          input logic exp_valid, input logic exp_conv);
    logic [15:0] g0;
    g0 = gain_out;
    avg_brightness = luma;
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_early_gain"}, 32'(gain_out), 32'(g0));
    check({tag, "_early_valid"}, 32'(gain_valid), 32'd0);
    @(negedge clk);
    check({tag, "_gain"}, 32'(gain_out), 32'(exp_gain));
    check({tag, "_valid"}, 32'(gain_valid), 32'(exp_valid));
    check({tag, "_conv"}, 32'(converged), 32'(exp_conv));
    @(negedge clk);
    check({tag, "_valid_end"}, 32'(gain_valid), 32'd0);
  endtask

  task automatic check_flags(input string tag, input logic mx, input logic mn);
    check({tag, "_at_max"}, 32'(at_max), 32'(mx));
    check({tag, "_at_min"}, 32'(at_min), 32'(mn));
  endtask

  task automatic quiet_cycles(input string tag, input int n, input logic [15:0] exp_gain);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gain_valid) pulses++;
    end
    check({tag, "_pulses"}, 32'(pulses), 32'd0);
    check({tag, "_gain"}, 32'(gain_out), 32'(exp_gain));
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    freeze = 1'b0;
    frame_done = 1'b0;
    avg_brightness = 8'd0;
    cfg_target = 8'd100;
    cfg_hyst = 8'd5;
    cfg_mode = 1'b0;
    cfg_fixed_step = 16'd4;

    @(negedge clk);
    @(negedge clk);
    check("rst_gain", 32'(gain_out), 32'd256);
    check("rst_valid", 32'(gain_valid), 32'd0);
    check("rst_conv", 32'(converged), 32'd0);
    check_flags("rst", 1'b0, 1'b0);
    rst = 1'b0;
    quiet_cycles("idle", 3, 16'd256);

    do_frame("fix1", 8'd60, 16'd260, 1'b1, 1'b0);
    do_frame("fix2", 8'd60, 16'd264, 1'b1, 1'b0);
    do_frame("fix3", 8'd60, 16'd268, 1'b1, 1'b0);

    enable = 1'b0;
    @(negedge clk);
    check("dis_gain", 32'(gain_out), 32'd256);
    check("dis_valid", 32'(gain_valid), 32'd0);
    enable = 1'b1;

    cfg_mode = 1'b1;
    do_frame("prop_up", 8'd20, 16'd276, 1'b1, 1'b0);
    do_frame("prop_ceil", 8'd240, 16'd244, 1'b1, 1'b0);
    cfg_hyst = 8'd0;
    do_frame("prop_floor", 8'd99, 16'd245, 1'b1, 1'b0);
    cfg_hyst = 8'd5;

    cfg_mode = 1'b0;
    cfg_fixed_step = 16'd755;
    do_frame("to1000", 8'd0, 16'd1000, 1'b1, 1'b0);
    check_flags("at1000", 1'b0, 1'b0);
    cfg_fixed_step = 16'd300;
    do_frame("sat_max", 8'd0, 16'd1024, 1'b1, 1'b0);
    check_flags("sat_max", 1'b1, 1'b0);
    cfg_fixed_step = 16'hFFFF;
    do_frame("carry", 8'd0, 16'd1024, 1'b1, 1'b0);
    cfg_fixed_step = 16'd2000;
    do_frame("sat_min", 8'd255, 16'd128, 1'b1, 1'b0);
    check_flags("sat_min", 1'b0, 1'b1);

    cfg_fixed_step = 16'd100;
    do_frame("up228", 8'd0, 16'd228, 1'b1, 1'b0);
    check_flags("up228", 1'b0, 1'b0);
    cfg_fixed_step = 16'd4;
    do_frame("win1", 8'd102, 16'd228, 1'b1, 1'b0);
    do_frame("win_lo", 8'd95, 16'd228, 1'b1, 1'b0);
    do_frame("win_hi", 8'd105, 16'd228, 1'b1, 1'b0);
    do_frame("win4", 8'd102, 16'd228, 1'b1, 1'b1);
    do_frame("leave_hi", 8'd110, 16'd224, 1'b1, 1'b0);
    do_frame("leave_lo", 8'd94, 16'd228, 1'b1, 1'b0);

    freeze = 1'b1;
    do_frame("freeze", 8'd0, 16'd228, 1'b0, 1'b0);
    freeze = 1'b0;

    avg_brightness = 8'd0;
    frame_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ign_gain", 32'(gain_out), 32'd232);
    check("ign_valid", 32'(gain_valid), 32'd1);
    quiet_cycles("ign_after", 6, 16'd232);

    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("mid_dis_gain", 32'(gain_out), 32'd256);
    check("mid_dis_valid", 32'(gain_valid), 32'd0);
    check_flags("mid_dis", 1'b0, 1'b0);
    enable = 1'b1;
    quiet_cycles("mid_dis_after", 5, 16'd256);

    do_frame("re260", 8'd0, 16'd260, 1'b1, 1'b0);
    enable = 1'b0;
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    enable = 1'b1;
    check("simul_gain", 32'(gain_out), 32'd256);
    quiet_cycles("simul_after", 5, 16'd256);

    do_frame("re260b", 8'd0, 16'd260, 1'b1, 1'b0);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_gain", 32'(gain_out), 32'd256);
    quiet_cycles("mid_rst_after", 5, 16'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
